// File: rtl/wb_arbiter_2m_if.sv
// Wishbone bundle shared by the arbiter, its two requesters and the BlockRAM slave.
// 32-bit word address and data, 4-bit byte select.
interface wshb_if;
    logic        cyc;
    logic        stb;
    logic        we;
    logic [3:0]  sel;
    logic [31:0] adr;
    logic [31:0] dat_ms;
    logic [31:0] dat_sm;
    logic        ack;
    logic        err;

    modport master (
        output cyc, stb, we, sel, adr, dat_ms,
        input  dat_sm, ack, err
    );

    modport slave (
        input  cyc, stb, we, sel, adr, dat_ms,
        output dat_sm, ack, err
    );
endinterface

// File: rtl/wb_arbiter_2m.sv
// Two-master round-robin Wishbone arbiter; grant is held for the whole bus cycle.
// Optional grant watchdog enabled by defining ARB_TIMEOUT_EN (limit set by TIMEOUT).
module wb_arbiter_2m #(
    parameter int TIMEOUT = 64
) (
    input  logic   clk,
    input  logic   rst,
    wshb_if.slave  wb_m0,
    wshb_if.slave  wb_m1,
    wshb_if.master wb_s
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t state_reg, state_next;
    logic   last_gnt_reg, last_gnt_next;
    logic   timeout_hit;

`ifdef ARB_TIMEOUT_EN
    localparam int CW = $clog2(TIMEOUT) + 1;

    logic [CW-1:0] wdt_reg, wdt_next;

    assign timeout_hit = (state_reg != IDLE) && (wdt_reg == CW'(TIMEOUT - 1));

    // Restart on every new grant and on every slave ack; count stalled owner cycles.
    always_comb begin
        wdt_next = wdt_reg;
        if (state_reg == IDLE || state_next != state_reg || wb_s.ack)
            wdt_next = '0;
        else
            wdt_next = wdt_reg + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            wdt_reg <= '0;
        else
            wdt_reg <= wdt_next;
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next    = state_reg;
        last_gnt_next = last_gnt_reg;
        unique case (state_reg)
            IDLE: begin
                if (wb_m0.cyc && wb_m1.cyc)
                    state_next = last_gnt_reg ? GNT0 : GNT1;
                else if (wb_m0.cyc)
                    state_next = GNT0;
                else if (wb_m1.cyc)
                    state_next = GNT1;
            end
            GNT0: begin
                if (timeout_hit) begin
                    state_next    = IDLE;
                    last_gnt_next = 1'b0;
                end else if (!wb_m0.cyc) begin
                    last_gnt_next = 1'b0;
                    state_next    = wb_m1.cyc ? GNT1 : IDLE;
                end
            end
            GNT1: begin
                if (timeout_hit) begin
                    state_next    = IDLE;
                    last_gnt_next = 1'b1;
                end else if (!wb_m1.cyc) begin
                    last_gnt_next = 1'b1;
                    state_next    = wb_m0.cyc ? GNT0 : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg    <= IDLE;
            last_gnt_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            last_gnt_reg <= last_gnt_next;
        end
    end

    // Pure routing: nothing reaches the slave in IDLE, slave responses go only to the owner.
    always_comb begin
        wb_s.cyc     = 1'b0;
        wb_s.stb     = 1'b0;
        wb_s.we      = 1'b0;
        wb_s.sel     = 4'h0;
        wb_s.adr     = 32'h0;
        wb_s.dat_ms  = 32'h0;
        wb_m0.dat_sm = 32'h0;
        wb_m0.ack    = 1'b0;
        wb_m0.err    = 1'b0;
        wb_m1.dat_sm = 32'h0;
        wb_m1.ack    = 1'b0;
        wb_m1.err    = 1'b0;
        unique case (state_reg)
            GNT0: begin
                wb_s.cyc     = wb_m0.cyc && !timeout_hit;
                wb_s.stb     = wb_m0.stb && !timeout_hit;
                wb_s.we      = wb_m0.we;
                wb_s.sel     = wb_m0.sel;
                wb_s.adr     = wb_m0.adr;
                wb_s.dat_ms  = wb_m0.dat_ms;
                wb_m0.dat_sm = wb_s.dat_sm;
                wb_m0.ack    = wb_s.ack;
                wb_m0.err    = wb_s.err || timeout_hit;
            end
            GNT1: begin
                wb_s.cyc     = wb_m1.cyc && !timeout_hit;
                wb_s.stb     = wb_m1.stb && !timeout_hit;
                wb_s.we      = wb_m1.we;
                wb_s.sel     = wb_m1.sel;
                wb_s.adr     = wb_m1.adr;
                wb_s.dat_ms  = wb_m1.dat_ms;
                wb_m1.dat_sm = wb_s.dat_sm;
                wb_m1.ack    = wb_s.ack;
                wb_m1.err    = wb_s.err || timeout_hit;
            end
            default: ;
        endcase
    end

endmodule
